// File: rtl/bartlett_pkg.sv
// Shared constants for the Bartlett DOA pipeline stages.
// Also holds the peak-search state type and a saturating 8-bit increment.
package bartlett_pkg;

    localparam int MATRIX_SIZE = 4;
    localparam int THETA_COUNT = 19;
    localparam int THETA_IDX_W = $clog2(THETA_COUNT);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } peak_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/doa_peak_search.sv
// Tracks the strongest P(theta) beat of a sweep and emits {index, power} once per sweep.
// Handshakes are AXI-stream: a beat moves only on a cycle where valid and ready are both 1.
module doa_peak_search #(
    parameter int NUM_SIZE    = 32,
    parameter int THETA_COUNT = bartlett_pkg::THETA_COUNT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2*NUM_SIZE-1:0]   s_axis_p_tdata,
    input  logic                    s_axis_p_tvalid,
    input  logic                    s_axis_p_tlast,
    input  logic                    s_axis_p_tuser,
    output logic                    s_axis_p_tready,
    output logic [NUM_SIZE+7:0]     m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);
    import bartlett_pkg::*;

    localparam logic [7:0] THETA_CNT8 = 8'(THETA_COUNT);

    peak_state_e                state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       first_q, first_d;
    logic signed [NUM_SIZE-1:0] best_pwr_q, best_pwr_d;
    logic [7:0]                 best_idx_q, best_idx_d;
    logic [NUM_SIZE+7:0]        res_data_q, res_data_d;
    logic                       res_err_q, res_err_d;

    logic                       beat_acc;
    logic                       take_beat;
    logic signed [NUM_SIZE-1:0] beat_pwr;
    logic signed [NUM_SIZE-1:0] cand_pwr;
    logic [7:0]                 cand_idx;
    logic [7:0]                 cnt_inc;
    logic                       cand_err;
    logic                       unused_upper;

    // Upper half of the beat carries nothing this stage needs.
    assign unused_upper = ^s_axis_p_tdata[2*NUM_SIZE-1:NUM_SIZE];

    assign beat_acc  = s_axis_p_tvalid & s_axis_p_tready;
    assign beat_pwr  = signed'(s_axis_p_tdata[NUM_SIZE-1:0]);
    // Strict compare keeps the earliest index on ties.
    assign take_beat = first_q | (beat_pwr > best_pwr_q);
    assign cand_pwr  = take_beat ? beat_pwr : best_pwr_q;
    assign cand_idx  = take_beat ? cnt_q : best_idx_q;
    assign cnt_inc   = sat_inc8(cnt_q);
    assign cand_err  = err_q | s_axis_p_tuser | (cnt_q >= THETA_CNT8);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
            first_q    <= 1'b1;
            best_pwr_q <= '0;
            best_idx_q <= 8'd0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            first_q    <= first_d;
            best_pwr_q <= best_pwr_d;
            best_idx_q <= best_idx_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (beat_acc && s_axis_p_tlast) state_d = ST_HOLD;
            ST_HOLD:  if (m_axis_tready)              state_d = ST_ACCUM;
            default:                                  state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        err_d      = err_q;
        first_d    = first_q;
        best_pwr_d = best_pwr_q;
        best_idx_d = best_idx_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        if (beat_acc) begin
            cnt_d      = cnt_inc;
            err_d      = cand_err;
            first_d    = 1'b0;
            best_pwr_d = cand_pwr;
            best_idx_d = cand_idx;
            if (s_axis_p_tlast) begin
                res_data_d = {cand_idx, cand_pwr};
                res_err_d  = cand_err | (cnt_inc != THETA_CNT8);
            end
        end
        // Result taken: the next sweep starts from a clean slate on the same edge.
        if (state_q == ST_HOLD && m_axis_tready) begin
            cnt_d   = 8'd0;
            err_d   = 1'b0;
            first_d = 1'b1;
        end
    end

    always_comb begin
        s_axis_p_tready = (state_q == ST_ACCUM);
        m_axis_tvalid   = (state_q == ST_HOLD);
        m_axis_tlast    = (state_q == ST_HOLD);
        m_axis_tdata    = res_data_q;
        m_axis_tuser    = res_err_q;
    end

endmodule

// File: tb/tb_doa_peak_search.sv
// Randomized bench for doa_peak_search against a sweep-level max/first-index model.
// Handshakes are AXI-stream: a beat moves only on a cycle where valid and ready are both 1.
module tb_doa_peak_search;

    localparam int THETA = 19;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tuser, s_tready;
    logic [39:0] m_tdata;
    logic        m_tvalid, m_tuser, m_tlast, m_tready;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;
    int n_results = 0;
    logic [39:0] got_data;
    logic        got_user;

    logic [40:0] exp_q[$];
    logic [31:0] pwr_a[0:31];
    bit          usr_a[0:31];

    doa_peak_search #(.NUM_SIZE(32), .THETA_COUNT(THETA)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_axis_p_tdata  (s_tdata),
        .s_axis_p_tvalid (s_tvalid),
        .s_axis_p_tlast  (s_tlast),
        .s_axis_p_tuser  (s_tuser),
        .s_axis_p_tready (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tuser    (m_tuser),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Peak = largest signed power, earliest index among equals; error = any tuser or wrong length.
    function automatic logic [40:0] model_result(input int n);
        logic signed [31:0] mx;
        int idx;
        bit e;
        mx = $signed(pwr_a[0]);
        for (int i = 1; i < n; i++) if ($signed(pwr_a[i]) > mx) mx = $signed(pwr_a[i]);
        idx = -1;
        for (int i = 0; i < n; i++) if (idx < 0 && $signed(pwr_a[i]) == mx) idx = i;
        e = (n != THETA);
        for (int i = 0; i < n; i++) e |= usr_a[i];
        return {e, 8'(idx), mx};
    endfunction

    // ---------------- drivers ----------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    task automatic send_beat(input logic [31:0] p, input bit u, input bit l);
        bit acc;
        int waited;
        acc = 0;
        waited = 0;
        s_tdata  = {$urandom(), p};
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 300) begin
                check("beat_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_sweep(input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(pwr_a[i], usr_a[i], with_last && (i == n - 1));
        end
        if (with_last) begin
            exp_q.push_back(model_result(n));
            check("latency_1", 64'(m_tvalid), 64'd1);
        end
    endtask

    task automatic clear_arrays();
        for (int i = 0; i < 32; i++) begin
            pwr_a[i] = 32'd0;
            usr_a[i] = 1'b0;
        end
    endtask

    task automatic expect_result(input string name, input int base, input logic [39:0] ed, input bit eu);
        int w;
        w = 0;
        while (n_results <= base && w < 500) begin @(posedge clk); w++; end
        #1;
        if (n_results <= base) check({name, "_timeout"}, 64'd0, 64'd1);
        else begin
            check({name, "_data"}, 64'(got_data), 64'(ed));
            check({name, "_user"}, 64'(got_user), 64'(eu));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata",  64'(m_tdata),  64'd0);
        check("rst_tuser",  64'(m_tuser),  64'd0);
        check("rst_tready", 64'(s_tready), 64'd1);
    endtask

    // ---------------- scoreboard / compare ----------------
    initial begin
        logic        prev_valid, prev_ready, prev_user;
        logic [39:0] prev_data;
        logic [40:0] e;
        prev_valid = 0; prev_ready = 0; prev_user = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 0;
            end else begin
                check("tlast_eq_tvalid", 64'(m_tlast), 64'(m_tvalid));
                check("in_ready_vs_hold", 64'(s_tready), 64'(!m_tvalid));
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", 64'(m_tvalid), 64'd1);
                    check("hold_data", 64'(m_tdata), 64'(prev_data));
                    check("hold_user", 64'(m_tuser), 64'(prev_user));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) check("unexpected_result", 64'(m_tdata), 64'hDEAD);
                    else begin
                        e = exp_q.pop_front();
                        check("result_data", 64'(m_tdata), 64'(e[39:0]));
                        check("result_user", 64'(m_tuser), 64'(e[40]));
                    end
                    got_data = m_tdata;
                    got_user = m_tuser;
                    n_results++;
                end
                prev_valid = m_tvalid;
                prev_ready = m_tready;
                prev_data  = m_tdata;
                prev_user  = m_tuser;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, n, w;
        reset_n  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        clear_arrays();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Ramp with a spike at index 7.
        clear_arrays();
        for (int i = 0; i < THETA; i++) pwr_a[i] = 32'(i * 10);
        pwr_a[7] = 32'd1000;
        base = n_results;
        send_sweep(THETA, 1, 0);
        expect_result("spike7", base, {8'd7, 32'd1000}, 1'b0);

        // All equal negatives, then -1 beats -5.
        clear_arrays();
        for (int i = 0; i < THETA; i++) pwr_a[i] = 32'hFFFF_FFFB;
        base = n_results;
        send_sweep(THETA, 1, 1);
        expect_result("all_neg5", base, {8'd0, 32'hFFFF_FFFB}, 1'b0);
        pwr_a[11] = 32'hFFFF_FFFF;
        base = n_results;
        send_sweep(THETA, 1, 0);
        expect_result("neg1_wins", base, {8'd11, 32'hFFFF_FFFF}, 1'b0);

        // Tie keeps the earlier index.
        clear_arrays();
        pwr_a[3] = 32'd50;
        pwr_a[12] = 32'd50;
        base = n_results;
        send_sweep(THETA, 1, 1);
        expect_result("tie", base, {8'd3, 32'd50}, 1'b0);

        // Short and long sweeps flag an error but still report the peak.
        clear_arrays();
        for (int i = 0; i < 32; i++) pwr_a[i] = 32'(i);
        base = n_results;
        send_sweep(10, 1, 0);
        expect_result("short10", base, {8'd9, 32'd9}, 1'b1);
        pwr_a[22] = 32'd500;
        base = n_results;
        send_sweep(25, 1, 0);
        expect_result("long25", base, {8'd22, 32'd500}, 1'b1);

        // Upstream tuser marks the sweep.
        clear_arrays();
        pwr_a[4] = 32'd77;
        usr_a[5] = 1'b1;
        base = n_results;
        send_sweep(THETA, 1, 0);
        expect_result("tuser", base, {8'd4, 32'd77}, 1'b1);

        // Single-beat sweep.
        clear_arrays();
        pwr_a[0] = 32'h8000_0000;
        base = n_results;
        send_sweep(1, 1, 0);
        expect_result("single", base, {8'd0, 32'h8000_0000}, 1'b1);

        // Back-pressure: result held, input blocked, then a clean next sweep.
        clear_arrays();
        pwr_a[2] = 32'd42;
        rdy_mode = 2;
        base = n_results;
        send_sweep(THETA, 1, 0);
        s_tdata  = {32'd0, 32'd999};
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_tready_low", 64'(s_tready), 64'd0);
            check("bp_tdata", 64'(m_tdata), 64'({8'd2, 32'd42}));
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rdy_mode = 0;
        expect_result("bp_release", base, {8'd2, 32'd42}, 1'b0);
        clear_arrays();
        for (int i = 0; i < THETA; i++) pwr_a[i] = 32'(i * 10);
        pwr_a[7] = 32'd1000;
        base = n_results;
        send_sweep(THETA, 1, 0);
        expect_result("after_bp", base, {8'd7, 32'd1000}, 1'b0);

        // Reset mid-sweep discards the partial sweep.
        clear_arrays();
        pwr_a[1] = 32'd5000;
        send_sweep(8, 0, 0);
        do_reset();
        clear_arrays();
        pwr_a[15] = 32'd123;
        base = n_results;
        send_sweep(THETA, 1, 0);
        expect_result("after_rst_mid", base, {8'd15, 32'd123}, 1'b0);

        // Reset during HOLD discards the pending result.
        rdy_mode = 2;
        clear_arrays();
        pwr_a[9] = 32'd9999;
        send_sweep(THETA, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        rdy_mode = 0;
        clear_arrays();
        pwr_a[6] = 32'd66;
        base = n_results;
        send_sweep(THETA, 1, 0);
        expect_result("after_rst_hold", base, {8'd6, 32'd66}, 1'b0);

        // Randomized sweeps with random back-pressure and gaps.
        rdy_mode = 1;
        for (int s = 0; s < 14; s++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : THETA;
            for (int i = 0; i < n; i++) begin
                pwr_a[i] = ($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 6)) - 3) : $urandom();
                usr_a[i] = ($urandom_range(0, 15) == 0);
            end
            send_sweep(n, 1, 1);
        end
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin @(posedge clk); w++; end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/doa_peak_search.md
DOA_PEAK_SEARCH -- requirements
Module: doa_peak_search

Interface
REQ-001 Parameter NUM_SIZE, default 32, bits per complex number {imag, real}; each half is NUM_SIZE/2 wide.
REQ-002 Parameter THETA_COUNT, default bartlett_pkg::THETA_COUNT (19), expected beats per theta sweep.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_axis_p_tdata  input  2*NUM_SIZE  P(theta) beat from the p_theta stage; bits [NUM_SIZE-1:0] hold signed power; upper half is ignored.
REQ-006 s_axis_p_tvalid, s_axis_p_tlast, s_axis_p_tuser  input  1 each  beat valid, end of sweep, upstream error flag.
REQ-007 s_axis_p_tready  output  1  beat accept.
REQ-008 m_axis_tdata  output  NUM_SIZE+8  {8'b peak theta index, NUM_SIZE-bit peak power}.
REQ-009 m_axis_tvalid, m_axis_tuser, m_axis_tlast  output  1 each  result valid, sweep error, constant 1 while valid.
REQ-010 m_axis_tready  input  1  downstream accept.

Function
REQ-011 FSM states SHALL be ACCUM and HOLD; reset state is ACCUM.
REQ-012 In ACCUM, s_axis_p_tready SHALL be 1; in HOLD it SHALL be 0.
REQ-013 A beat is accepted only when s_axis_p_tvalid and s_axis_p_tready are both 1.
REQ-014 Beat counter SHALL be 8 bits, 0 at sweep start, +1 per accepted beat, saturating at 255.
REQ-015 The first accepted beat of a sweep SHALL load best power and best index (0) unconditionally.
REQ-016 Later beats SHALL replace the best only if their power is strictly greater (signed compare); ties keep the earlier index.
REQ-017 Sticky error SHALL be set by any accepted beat with s_axis_p_tuser=1, or by a beat accepted while the counter is already >= THETA_COUNT.
REQ-018 On the accepted tlast beat: include it in the compare; set error if total beats != THETA_COUNT; latch the result; go to HOLD.
REQ-019 m_axis_tvalid SHALL rise on the cycle after the tlast beat is accepted (latency 1), with tdata and tuser stable until the handshake.
REQ-020 In HOLD, m_axis_tvalid=1; on m_axis_tready=1 go to ACCUM and clear counter, error and first-beat flag in the same edge.
REQ-021 m_axis_tvalid SHALL never drop without a handshake; a new sweep is not accepted until the result is taken, so there is 1 bubble cycle minimum.
REQ-022 A sweep of a single beat with tlast is legal: that beat is the peak, index 0, and error=1 unless THETA_COUNT=1.
REQ-023 m_axis_tlast SHALL equal m_axis_tvalid.

Reset
REQ-024 On reset_n low: state ACCUM, counter 0, error 0, best 0, m_axis_tvalid 0, m_axis_tuser 0, m_axis_tdata 0; outputs 0 one cycle after deassertion except s_axis_p_tready=1.
REQ-025 Reset mid-sweep or during HOLD SHALL discard the partial or pending result; no result beat is emitted for it.

Structure
REQ-026 MATRIX_SIZE (4), THETA_COUNT (19) and THETA_IDX_W SHALL live in shared package bartlett_pkg, which the neighbouring stages also use.
REQ-027 The design SHALL be a single module with no sub-module; the compare/latch datapath and the 2-state FSM are in one place.

Verification
REQ-028 19 beats with power = index*10 except index 7 = 1000, tlast on beat 18 -> one result {8'd7, 1000}, tuser 0, valid the cycle after tlast.
REQ-029 19 beats, all power -5 (0xFFFFFFFB) -> index 0, power -5, tuser 0; signed compare verified with a beat of -1 beating -5 in a second run.
REQ-030 Ties: power 50 at indices 3 and 12, all others 0 -> index 3.
REQ-031 Short sweep of 10 beats with tlast on beat 9 -> valid result, tuser 1; a 25-beat sweep -> tuser 1, and the peak is still computed over all 25 beats.
REQ-032 Hold m_axis_tready=0 for 20 cycles after the result -> tvalid and tdata stable, s_axis_p_tready 0, no input beats accepted; release -> next sweep starts with a clean counter.
REQ-033 Assert reset_n low for 1 cycle after 8 beats of a sweep, then send a full sweep -> only the second sweep's result appears.
